// File: rtl/mem_ctrl_mp_pkg.sv
// mem_ctrl_mp_pkg
// Shared definitions for the multi-port byte-serialising memory controller:
//   - RISC-V funct3 load/store size codes
//   - FSM state encoding
//   - IO window prefix (address bits 17:16) used for UART back-pressure
//   - size_bytes(): funct3 -> number of byte beats (1, 2 or 4)
//   - load_extend(): sign/zero extension of the reassembled load word
package mem_ctrl_mp_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Accesses whose address has this value on bits 17:16 target the IO space.
  localparam logic [1:0] IO_PREFIX = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_e;

  // Number of byte beats for an access; unknown codes are treated as a word.
  function automatic logic [2:0] size_bytes(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: size_bytes = 3'd1;
      F3_H, F3_HU: size_bytes = 3'd2;
      default:     size_bytes = 3'd4;
    endcase
  endfunction

  // Signed types replicate the top byte/half, unsigned types fill with zero.
  function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                              input logic [2:0]  f3);
    case (f3)
      F3_B:    load_extend = {{24{raw[7]}}, raw[7:0]};
      F3_H:    load_extend = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   load_extend = {24'h0, raw[7:0]};
      F3_HU:   load_extend = {16'h0, raw[15:0]};
      default: load_extend = raw;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_mp_rr_arbiter.sv
// mem_ctrl_mp_rr_arbiter
// Combinational round-robin arbiter. Picks the first asserted request found
// when searching upward (with wrap) from index ptr. The pointer register
// itself lives in the parent so it only advances on an actual grant.
// Ports:
//   req   in  N_PORTS  request vector (already masked by the parent)
//   ptr   in  SRC_W    index where the search starts
//   grant out N_PORTS  one-hot grant, all zero when nobody requests
//   idx   out SRC_W    binary index of the granted port (0 when none)
module mem_ctrl_mp_rr_arbiter #(
  parameter int N_PORTS = 2,
  parameter int SRC_W   = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [N_PORTS-1:0] grant,
  output logic [SRC_W-1:0]   idx
);

  // Walk the offsets from farthest to nearest so that the nearest asserted
  // request (the one closest to ptr) is the last to overwrite the result.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int off = N_PORTS - 1; off >= 0; off--) begin
      if (req[(int'(ptr) + off) % N_PORTS]) begin
        grant = '0;
        grant[(int'(ptr) + off) % N_PORTS] = 1'b1;
        idx = SRC_W'((int'(ptr) + off) % N_PORTS);
      end
    end
  end

endmodule

// File: rtl/mem_ctrl_mp.sv
// mem_ctrl_mp
// Multi-port memory controller. Arbitrates N_PORTS requesters onto a single
// byte-wide RAM/IO bus, serialising 1/2/4-byte accesses into byte beats and
// reassembling loads little-endian with sign/zero extension.
// Ports:
//   clk_in          in   clock
//   rst_in          in   synchronous active-high reset
//   rdy_in          in   global pause; all state freezes while low
//   req_valid       in   per-port request, held until acked
//   req_r_nw        in   per-port 1 = read, 0 = write
//   req_type        in   per-port funct3 (3 bits each)
//   req_addr        in   per-port byte address (32 bits each)
//   req_data        in   per-port store data (32 bits each)
//   flush_in        in   per-port cancel of a pending/in-flight read
//   data_out        out  extended load result (0 for writes)
//   data_valid      out  one-cycle completion pulse
//   data_src        out  index of the completing port
//   mem_din         in   read byte, valid the cycle after its address
//   mem_dout        out  write byte
//   mem_a           out  byte address
//   mem_wr          out  write strobe
//   io_buffer_full  in   UART buffer full, stalls IO-space writes
module mem_ctrl_mp #(
  parameter int N_PORTS = 2,
  parameter int SRC_W   = $clog2(N_PORTS)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic [N_PORTS-1:0]     req_valid,
  input  logic [N_PORTS-1:0]     req_r_nw,
  input  logic [3*N_PORTS-1:0]   req_type,
  input  logic [32*N_PORTS-1:0]  req_addr,
  input  logic [32*N_PORTS-1:0]  req_data,
  input  logic [N_PORTS-1:0]     flush_in,
  output logic [31:0]            data_out,
  output logic                   data_valid,
  output logic [SRC_W-1:0]       data_src,
  input  logic [7:0]             mem_din,
  output logic [7:0]             mem_dout,
  output logic [31:0]            mem_a,
  output logic                   mem_wr,
  input  logic                   io_buffer_full
);

  import mem_ctrl_mp_pkg::*;

  state_e             state_q, state_d;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]   port_q, port_d;
  logic               rd_q, rd_d;
  logic [2:0]         type_q, type_d;
  logic [2:0]         k_q, k_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        lanes_q, lanes_d;
  logic [31:0]        data_out_q, data_out_d;
  logic               data_valid_q, data_valid_d;
  logic [SRC_W-1:0]   data_src_q, data_src_d;
  logic [31:0]        mem_a_q, mem_a_d;
  logic [7:0]         mem_dout_q, mem_dout_d;

  logic [N_PORTS-1:0] arb_req;
  logic [N_PORTS-1:0] arb_grant;
  logic [SRC_W-1:0]   arb_idx;
  logic               arb_any;

  logic               sel_rnw;
  logic [2:0]         sel_type;
  logic [31:0]        sel_addr;
  logic [31:0]        sel_data;

  logic               stall;
  logic               rd_flush;
  logic [1:0]         lane;
  logic [2:0]         nxt;

  // A port that is asking to flush is not eligible for a grant this cycle,
  // which lets another port win instead.
  assign arb_req = req_valid & ~flush_in;
  assign arb_any = |arb_grant;

  mem_ctrl_mp_rr_arbiter #(
    .N_PORTS (N_PORTS),
    .SRC_W   (SRC_W)
  ) u_arb (
    .req   (arb_req),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  // Pick out the granted port's request fields.
  always_comb begin
    sel_rnw  = req_r_nw[arb_idx];
    sel_type = req_type[3*int'(arb_idx) +: 3];
    sel_addr = req_addr[32*int'(arb_idx) +: 32];
    sel_data = req_data[32*int'(arb_idx) +: 32];
  end

  // IO back-pressure is decided on the base address of the access, and the
  // read-owner flush is looked up on the port that currently owns the FSM.
  assign stall    = (addr_q[17:16] == IO_PREFIX) && io_buffer_full;
  assign rd_flush = rd_q && flush_in[port_q];

  // The write strobe reacts to io_buffer_full in the same cycle so that a
  // byte is never presented to a full UART; the address/data it qualifies
  // are registered. A read owner flushing while in DONE must not see its
  // completion, so the pulse is masked combinationally as well.
  assign mem_wr     = (state_q == ST_WRITE) && !stall;
  assign data_valid = data_valid_q && !rd_flush;
  assign data_out   = data_out_q;
  assign data_src   = data_src_q;
  assign mem_a      = mem_a_q;
  assign mem_dout   = mem_dout_q;

  // Next-state logic. Reads use cnt as "beats issued so far": the address of
  // beat i goes out while cnt = i+1, and its byte returns when cnt = i+2, so
  // lane cnt-2 is filled each cycle from cnt = 2 up to cnt = k+1. Writes use
  // cnt as the index of the beat currently on the bus.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    port_d       = port_q;
    rd_d         = rd_q;
    type_d       = type_q;
    k_d          = k_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    lanes_d      = lanes_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    data_src_d   = data_src_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    lane         = 2'(cnt_q - 3'd2);
    nxt          = cnt_q + 3'd1;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          port_d   = arb_idx;
          rd_d     = sel_rnw;
          type_d   = sel_type;
          k_d      = size_bytes(sel_type);
          addr_d   = sel_addr;
          wdata_d  = sel_data;
          lanes_d  = '0;
          mem_a_d  = sel_addr;
          rr_ptr_d = (arb_idx == SRC_W'(N_PORTS - 1)) ? '0 : arb_idx + 1'b1;
          if (sel_rnw) begin
            state_d    = ST_READ;
            cnt_d      = 3'd1;
            mem_dout_d = 8'h00;
          end else begin
            state_d    = ST_WRITE;
            cnt_d      = 3'd0;
            mem_dout_d = sel_data[7:0];
          end
        end
      end

      ST_READ: begin
        if (rd_flush) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
          mem_a_d = '0;
        end else begin
          if (cnt_q >= 3'd2) begin
            lanes_d[{lane, 3'b000} +: 8] = mem_din;
          end
          if (cnt_q == k_q + 3'd1) begin
            state_d      = ST_DONE;
            data_valid_d = 1'b1;
            data_src_d   = port_q;
            data_out_d   = load_extend(lanes_d, type_q);
            mem_a_d      = '0;
          end else begin
            mem_a_d = (cnt_q == k_q) ? 32'h0 : addr_q + 32'(cnt_q);
            cnt_d   = nxt;
          end
        end
      end

      ST_WRITE: begin
        if (!stall) begin
          if (cnt_q == k_q - 3'd1) begin
            state_d      = ST_DONE;
            data_valid_d = 1'b1;
            data_src_d   = port_q;
            data_out_d   = '0;
            mem_a_d      = '0;
            mem_dout_d   = 8'h00;
          end else begin
            cnt_d      = nxt;
            mem_a_d    = addr_q + 32'(nxt);
            mem_dout_d = wdata_q[{nxt[1:0], 3'b000} +: 8];
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All state, including the registered outputs, is cleared by reset and
  // frozen whenever rdy_in is low so that a pause shifts every later event.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      port_q       <= '0;
      rd_q         <= 1'b0;
      type_q       <= 3'd0;
      k_q          <= 3'd0;
      cnt_q        <= 3'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      lanes_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      data_src_q   <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= 8'h00;
    end else if (rdy_in) begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      port_q       <= port_d;
      rd_q         <= rd_d;
      type_q       <= type_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      lanes_q      <= lanes_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      data_src_q   <= data_src_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl_mp.sv
// tb_mem_ctrl_mp
// Directed bench for mem_ctrl_mp: a 2-port instance backed by a small
// read-only byte memory, plus a 3-port instance used for fairness ordering.
module tb_mem_ctrl_mp;

  import mem_ctrl_mp_pkg::*;

  localparam int NP = 2;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic              rdy_in = 1'b1;
  logic [NP-1:0]     req_valid = '0;
  logic [NP-1:0]     req_r_nw = '0;
  logic [3*NP-1:0]   req_type = '0;
  logic [32*NP-1:0]  req_addr = '0;
  logic [32*NP-1:0]  req_data = '0;
  logic [NP-1:0]     flush_in = '0;
  logic [31:0]       data_out;
  logic              data_valid;
  logic [0:0]        data_src;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [31:0]       mem_a;
  logic              mem_wr;
  logic              io_buffer_full = 1'b0;

  logic [2:0]        r3_valid = '0;
  logic [2:0]        r3_rnw = '0;
  logic [8:0]        r3_type = '0;
  logic [95:0]       r3_addr = '0;
  logic [95:0]       r3_data = '0;
  logic [2:0]        r3_flush = '0;
  logic [31:0]       d3_data_out;
  logic              d3_data_valid;
  logic [1:0]        d3_data_src;
  logic [7:0]        d3_mem_din = 8'h00;
  logic [7:0]        d3_mem_dout;
  logic [31:0]       d3_mem_a;
  logic              d3_mem_wr;
  logic              d3_io_full = 1'b0;

  int cyc = 0;
  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] mem [0:4095];

  int          ack_cyc[$];
  logic [31:0] ack_data[$];
  int          ack_src[$];
  int          wr_cyc[$];
  logic [31:0] wr_addr[$];
  logic [7:0]  wr_byte[$];
  int          ack3_cyc[$];
  int          ack3_src[$];

  mem_ctrl_mp #(.N_PORTS(NP)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .req_valid      (req_valid),
    .req_r_nw       (req_r_nw),
    .req_type       (req_type),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .flush_in       (flush_in),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .data_src       (data_src),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  mem_ctrl_mp #(.N_PORTS(3)) dut3 (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .req_valid      (r3_valid),
    .req_r_nw       (r3_rnw),
    .req_type       (r3_type),
    .req_addr       (r3_addr),
    .req_data       (r3_data),
    .flush_in       (r3_flush),
    .data_out       (d3_data_out),
    .data_valid     (d3_data_valid),
    .data_src       (d3_data_src),
    .mem_din        (d3_mem_din),
    .mem_dout       (d3_mem_dout),
    .mem_a          (d3_mem_a),
    .mem_wr         (d3_mem_wr),
    .io_buffer_full (d3_io_full)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk_in = ~clk_in;

  // Cycle index: during a cycle, cyc equals the number of rising edges seen.
  always @(posedge clk_in) cyc <= cyc + 1;

  // Byte memory with one cycle of read latency; it pauses with the system.
  always @(posedge clk_in) begin
    if (rdy_in) mem_din <= mem[mem_a[11:0]];
  end

  // Log every completion and every write strobe, tagged with its cycle.
  always @(negedge clk_in) begin
    if (data_valid) begin
      ack_cyc.push_back(cyc);
      ack_data.push_back(data_out);
      ack_src.push_back(int'(data_src));
    end
    if (mem_wr) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(mem_a);
      wr_byte.push_back(mem_dout);
    end
    if (d3_data_valid) begin
      ack3_cyc.push_back(cyc);
      ack3_src.push_back(int'(d3_data_src));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic clear_logs();
    ack_cyc.delete(); ack_data.delete(); ack_src.delete();
    wr_cyc.delete(); wr_addr.delete(); wr_byte.delete();
    ack3_cyc.delete(); ack3_src.delete();
  endtask

  task automatic issue(input int p, input logic rnw, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    req_valid[p]        = 1'b1;
    req_r_nw[p]         = rnw;
    req_type[3*p +: 3]  = f3;
    req_addr[32*p +: 32] = a;
    req_data[32*p +: 32] = d;
  endtask

  task automatic drop(input int p);
    req_valid[p] = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick(2);
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    tick(3);
    tests_run++;
    if (data_out !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_data_out: got %h expected 0", data_out); end
    tests_run++;
    if (data_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_data_valid: got %b expected 0", data_valid); end
    tests_run++;
    if (data_src !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_data_src: got %0d expected 0", data_src); end
    tests_run++;
    if (mem_a !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_mem_a: got %h expected 0", mem_a); end
    tests_run++;
    if (mem_dout !== 8'h0) begin tests_failed++; $display("[TB] FAIL reset_mem_dout: got %h expected 0", mem_dout); end
    tests_run++;
    if (mem_wr !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_mem_wr: got %b expected 0", mem_wr); end
    rst_in = 1'b0;
    tick(1);
  endtask

  task automatic test_lw();
    int t;
    clear_logs();
    t = cyc;
    issue(0, 1'b1, F3_W, 32'h100, 32'h0);
    tick(7);
    drop(0);
    tick(2);
    tests_run++;
    if (ack_cyc.size() !== 1) begin
      tests_failed++; $display("[TB] FAIL lw_ack_count: got %0d expected 1", ack_cyc.size());
    end else begin
      tests_run++;
      if (ack_cyc[0] !== t + 6) begin tests_failed++; $display("[TB] FAIL lw_ack_cycle: got T+%0d expected T+6", ack_cyc[0] - t); end
      tests_run++;
      if (ack_data[0] !== 32'h12345678) begin tests_failed++; $display("[TB] FAIL lw_data: got %h expected 12345678", ack_data[0]); end
      tests_run++;
      if (ack_src[0] !== 0) begin tests_failed++; $display("[TB] FAIL lw_src: got %0d expected 0", ack_src[0]); end
    end
    tests_run++;
    if (wr_cyc.size() !== 0) begin tests_failed++; $display("[TB] FAIL lw_no_write: got %0d strobes expected 0", wr_cyc.size()); end
  endtask

  task automatic test_lb_lbu();
    int t1;
    int t2;
    clear_logs();
    t1 = cyc;
    issue(0, 1'b1, F3_B, 32'h80, 32'h0);
    tick(4);
    drop(0);
    tick(1);
    t2 = cyc;
    issue(0, 1'b1, F3_BU, 32'h80, 32'h0);
    tick(4);
    drop(0);
    tick(2);
    tests_run++;
    if (ack_cyc.size() !== 2) begin
      tests_failed++; $display("[TB] FAIL lb_ack_count: got %0d expected 2", ack_cyc.size());
    end else begin
      tests_run++;
      if (ack_data[0] !== 32'hFFFFFF80) begin tests_failed++; $display("[TB] FAIL lb_sign_ext: got %h expected ffffff80", ack_data[0]); end
      tests_run++;
      if (ack_data[1] !== 32'h00000080) begin tests_failed++; $display("[TB] FAIL lbu_zero_ext: got %h expected 00000080", ack_data[1]); end
      tests_run++;
      if (ack_cyc[0] !== t1 + 3) begin tests_failed++; $display("[TB] FAIL lb_ack_cycle: got T+%0d expected T+3", ack_cyc[0] - t1); end
      tests_run++;
      if (ack_cyc[1] !== t2 + 3) begin tests_failed++; $display("[TB] FAIL lbu_ack_cycle: got T+%0d expected T+3", ack_cyc[1] - t2); end
    end
  endtask

  task automatic test_round_robin();
    int t;
    int exp_src[4] = '{0, 1, 0, 1};
    logic [31:0] exp_data[2] = '{32'h12345678, 32'hDEADBEEF};
    do_reset();
    clear_logs();
    t = cyc;
    issue(0, 1'b1, F3_W, 32'h100, 32'h0);
    issue(1, 1'b1, F3_W, 32'h200, 32'h0);
    tick(28);
    drop(0);
    drop(1);
    tick(2);
    tests_run++;
    if (ack_cyc.size() !== 4) begin
      tests_failed++; $display("[TB] FAIL rr_ack_count: got %0d expected 4", ack_cyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (ack_src[i] !== exp_src[i] || ack_cyc[i] !== t + 6 + 7*i || ack_data[i] !== exp_data[exp_src[i]]) begin
          tests_failed++;
          $display("[TB] FAIL rr_grant%0d: got src %0d at T+%0d data %h expected src %0d at T+%0d data %h",
                   i, ack_src[i], ack_cyc[i] - t, ack_data[i], exp_src[i], 6 + 7*i, exp_data[exp_src[i]]);
        end
      end
    end
  endtask

  task automatic test_three_ports();
    int t;
    int exp_src[4] = '{0, 1, 2, 0};
    do_reset();
    clear_logs();
    t = cyc;
    r3_valid = 3'b111;
    r3_rnw   = 3'b111;
    r3_type  = {F3_B, F3_B, F3_B};
    tick(16);
    r3_valid = 3'b000;
    tick(2);
    tests_run++;
    if (ack3_cyc.size() !== 4) begin
      tests_failed++; $display("[TB] FAIL rr3_ack_count: got %0d expected 4", ack3_cyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (ack3_src[i] !== exp_src[i] || ack3_cyc[i] !== t + 3 + 4*i) begin
          tests_failed++;
          $display("[TB] FAIL rr3_grant%0d: got src %0d at T+%0d expected src %0d at T+%0d",
                   i, ack3_src[i], ack3_cyc[i] - t, exp_src[i], 3 + 4*i);
        end
      end
    end
  endtask

  task automatic test_io_stall();
    int t;
    clear_logs();
    t = cyc;
    issue(0, 1'b0, F3_B, 32'h30000, 32'h41);
    tick(1);
    io_buffer_full = 1'b1;
    tick(3);
    io_buffer_full = 1'b0;
    tick(2);
    drop(0);
    tick(2);
    tests_run++;
    if (wr_cyc.size() !== 1) begin
      tests_failed++; $display("[TB] FAIL io_wr_count: got %0d expected 1", wr_cyc.size());
    end else begin
      tests_run++;
      if (wr_cyc[0] !== t + 4) begin tests_failed++; $display("[TB] FAIL io_wr_cycle: got T+%0d expected T+4", wr_cyc[0] - t); end
      tests_run++;
      if (wr_byte[0] !== 8'h41 || wr_addr[0] !== 32'h30000) begin
        tests_failed++; $display("[TB] FAIL io_wr_value: got %h@%h expected 41@00030000", wr_byte[0], wr_addr[0]);
      end
    end
    tests_run++;
    if (ack_cyc.size() !== 1 || ack_cyc[0] !== t + 5) begin
      tests_failed++; $display("[TB] FAIL io_ack: got %0d acks first at T+%0d expected 1 at T+5", ack_cyc.size(), ack_cyc.size() > 0 ? ack_cyc[0] - t : -1);
    end
  endtask

  task automatic test_flush_read();
    int t;
    clear_logs();
    t = cyc;
    issue(1, 1'b1, F3_W, 32'h200, 32'h0);
    tick(1);
    issue(0, 1'b1, F3_W, 32'h100, 32'h0);
    tick(2);
    flush_in[1] = 1'b1;
    drop(1);
    tick(1);
    flush_in[1] = 1'b0;
    tests_run++;
    if (mem_a !== 32'h0) begin tests_failed++; $display("[TB] FAIL flush_idle_mem_a: got %h expected 0", mem_a); end
    tick(1);
    tests_run++;
    if (mem_a !== 32'h100) begin tests_failed++; $display("[TB] FAIL flush_regrant_mem_a: got %h expected 00000100", mem_a); end
    tick(5);
    tick(1);
    drop(0);
    tick(2);
    tests_run++;
    if (ack_cyc.size() !== 1) begin
      tests_failed++; $display("[TB] FAIL flush_ack_count: got %0d expected 1", ack_cyc.size());
    end else begin
      tests_run++;
      if (ack_src[0] !== 0 || ack_cyc[0] !== t + 10 || ack_data[0] !== 32'h12345678) begin
        tests_failed++;
        $display("[TB] FAIL flush_port0_ack: got src %0d at T+%0d data %h expected src 0 at T+10 data 12345678",
                 ack_src[0], ack_cyc[0] - t, ack_data[0]);
      end
    end
  endtask

  task automatic test_flush_write();
    int t;
    logic [7:0] exp_b[4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    clear_logs();
    t = cyc;
    issue(1, 1'b0, F3_W, 32'h40, 32'hA1B2C3D4);
    tick(2);
    flush_in[1] = 1'b1;
    tick(4);
    drop(1);
    flush_in[1] = 1'b0;
    tick(2);
    tests_run++;
    if (wr_cyc.size() !== 4) begin
      tests_failed++; $display("[TB] FAIL sw_flush_wr_count: got %0d expected 4", wr_cyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (wr_byte[i] !== exp_b[i] || wr_addr[i] !== 32'h40 + i || wr_cyc[i] !== t + 1 + i) begin
          tests_failed++;
          $display("[TB] FAIL sw_flush_byte%0d: got %h@%h at T+%0d expected %h@%h at T+%0d",
                   i, wr_byte[i], wr_addr[i], wr_cyc[i] - t, exp_b[i], 32'h40 + i, 1 + i);
        end
      end
    end
    tests_run++;
    if (ack_cyc.size() !== 1 || ack_cyc[0] !== t + 5 || ack_src[0] !== 1) begin
      tests_failed++;
      $display("[TB] FAIL sw_flush_ack: got %0d acks first at T+%0d src %0d expected 1 at T+5 src 1",
               ack_cyc.size(), ack_cyc.size() > 0 ? ack_cyc[0] - t : -1, ack_src.size() > 0 ? ack_src[0] : -1);
    end
  endtask

  task automatic test_pause();
    int t;
    clear_logs();
    t = cyc;
    issue(0, 1'b1, F3_W, 32'h100, 32'h0);
    tick(2);
    rdy_in = 1'b0;
    tick(2);
    rdy_in = 1'b1;
    tick(5);
    drop(0);
    tick(2);
    tests_run++;
    if (ack_cyc.size() !== 1) begin
      tests_failed++; $display("[TB] FAIL pause_ack_count: got %0d expected 1", ack_cyc.size());
    end else begin
      tests_run++;
      if (ack_cyc[0] !== t + 8) begin tests_failed++; $display("[TB] FAIL pause_ack_cycle: got T+%0d expected T+8", ack_cyc[0] - t); end
      tests_run++;
      if (ack_data[0] !== 32'h12345678) begin tests_failed++; $display("[TB] FAIL pause_data: got %h expected 12345678", ack_data[0]); end
    end
  endtask

  task automatic test_reset_mid_write();
    clear_logs();
    issue(0, 1'b0, F3_W, 32'h50, 32'h11223344);
    tick(2);
    rst_in = 1'b1;
    drop(0);
    tick(1);
    tests_run++;
    if (mem_wr !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_write_mem_wr: got %b expected 0", mem_wr); end
    rst_in = 1'b0;
    tick(6);
    tests_run++;
    if (ack_cyc.size() !== 0) begin tests_failed++; $display("[TB] FAIL rst_write_no_ack: got %0d acks expected 0", ack_cyc.size()); end
    tests_run++;
    if (wr_cyc.size() !== 2) begin tests_failed++; $display("[TB] FAIL rst_write_strobes: got %0d expected 2", wr_cyc.size()); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h100] = 8'h78; mem[12'h101] = 8'h56; mem[12'h102] = 8'h34; mem[12'h103] = 8'h12;
    mem[12'h200] = 8'hEF; mem[12'h201] = 8'hBE; mem[12'h202] = 8'hAD; mem[12'h203] = 8'hDE;
    mem[12'h080] = 8'h80;

    test_reset();
    test_lw();
    test_lb_lbu();
    test_round_robin();
    test_three_ports();
    test_io_stall();
    test_flush_read();
    test_flush_write();
    test_pause();
    test_reset_mid_write();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_ctrl_mp.md
# mem_ctrl_mp

Parametrised multi-port memory controller. It arbitrates N_PORTS load/store requesters (instruction cache, load/store buffer, future data cache or prefetcher) onto the single byte-wide RAM/IO bus. Each access of 1, 2 or 4 bytes is serialised as a sequence of byte accesses and reassembled into a little-endian 32-bit result. It generalises the current two-requester controller with:
- round-robin fairness;
- per-port flush of in-flight reads;
- IO-full back-pressure on stores;
- sign/zero extension done in the controller rather than by each requester.

## Interface
Parameters:
- N_PORTS, 2, number of requesters (≥2)
- SRC_W, $clog2(N_PORTS), width of response source index

Ports:
- clk_in  in  1  system clock; one clock domain
- rst_in  in  1  synchronous, active-high reset
- rdy_in  in  1  global pause; when low, all state, counters and outputs freeze
- req_valid  in  N_PORTS  per-port request, level-held until acked
- req_r_nw  in  N_PORTS  1 = read, 0 = write
- req_type  in  3*N_PORTS  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  32*N_PORTS  byte address
- req_data  in  32*N_PORTS  store data, low bytes used
- flush_in  in  N_PORTS  cancel that port's pending or in-flight read
- data_out  out  32  extended load result (0 for writes)
- data_valid  out  1  one-cycle completion pulse
- data_src  out  SRC_W  index of the completing port
- mem_din  in  8  RAM/IO read byte; valid in the cycle after the address is driven
- mem_dout  out  8  write byte
- mem_a  out  32  byte address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  UART buffer full

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: the round-robin arbiter picks the first port with req_valid & ~flush_in, searching from rr_ptr. The controller latches addr/type/data/port and loads byte count k (B=1, H=2, W=4). It moves to READ or WRITE.
- rr_ptr becomes (granted+1) mod N_PORTS on grant. Reset sets rr_ptr = 0.
- READ: drives mem_a = addr+i for i = 0..k-1, with mem_wr = 0. Byte i from mem_din is stored into lane i one cycle later. After the last byte the FSM enters DONE.
- Extension: B/H are sign-extended; BU/HU are zero-extended.
- WRITE: drives mem_a = addr+i, mem_dout = data[8i+7:8i], mem_wr = 1 for i = 0..k-1. Then DONE.
- IO stall: if addr[17:16] == 2'b11 and io_buffer_full = 1, the write byte is held with mem_wr = 0 and i is not advanced. The byte retries each cycle until the buffer is no longer full.
- DONE: pulses data_valid, drives data_src = port and data_out = result, then returns to IDLE.
- Requester rule: deassert or change req_valid at the edge that ends its ack cycle. IDLE resamples on the following cycle.
- Flush, read owner: flush_in[owner] = 1 during READ or DONE aborts the access. The FSM goes to IDLE next cycle with no data_valid, and mem_wr is never asserted.
- Flush, write owner: flush_in is ignored on a write owner; writes always complete and ack.
- Unaligned addresses are legal; bytes are simply sequential.
- Idle outputs: mem_a = 0, mem_wr = 0, mem_dout = 0.

## Timing
- Request present in cycle T while IDLE → mem_a = addr+i-1 in cycles T+1..T+k.
- Read result: data_valid in cycle T+k+2 (LW T+6, LB T+3).
- Write: mem_wr high in T+1..T+k, ack in T+k+1. Each IO-full cycle adds one cycle.
- Back-to-back: next grant is sampled at the earliest one cycle after the ack (ack cycle is DONE, next cycle is IDLE).
- rdy_in low for n cycles delays every later event by exactly n cycles. Register contents are preserved.
- Reset: state = IDLE; rr_ptr = 0; data_out = 0; data_valid = 0; data_src = 0; mem_a = 0; mem_dout = 0; mem_wr = 0. Reset mid-access drops the access with no ack and no further mem_wr.
- Grant-cycle flush: flush_in and req_valid of the same port both high in IDLE → that port is skipped this cycle and another port may win.

## Structure
- Shared package: funct3 type codes, FSM state enum, IO_PREFIX constant (2'b11 on bits 17:16), size-decode function (type → k).
- Sub-module rr_arbiter #(N_PORTS): inputs req and ptr; outputs one-hot grant plus index. Purely combinational; rr_ptr lives in the parent.
- Load extension is a function in the package.

## Test plan
- Single LW at 0x100 holding bytes 78 56 34 12 on port 0, request at T → data_out = 0x12345678, data_src = 0, data_valid only in T+6.
- LB at 0x80 (byte 0x80), then LBU at the same address → 0xFFFFFF80 then 0x00000080.
- Ports 0 and 1 both holding LW requests continuously from reset → grants in order 0, 1, 0, 1, each ack 7 cycles apart, no starvation. With N_PORTS = 3 and all requesting → order 0, 1, 2, 0.
- SB 0x41 to 0x30000 with io_buffer_full high for 3 cycles → mem_wr low for those 3 cycles, one mem_wr pulse with mem_dout = 0x41, ack 3 cycles later than nominal.
- LW in flight on port 1, flush_in[1] pulsed in T+3 → no data_valid for port 1, IDLE in T+4, a pending port 0 request is granted in T+4. SW flushed mid-way instead → all 4 bytes are written and acked.
- rdy_in low for 2 cycles during READ → data_valid in T+8 with an unchanged value. rst_in during WRITE → mem_wr = 0 the next cycle and no ack.
